// File: rtl/temp_alarm_ctrl.sv
// Temperature alarm/shutdown sequencer: debounced NORMAL/WARN/SHUTDOWN FSM.
// Optional sensor-loss timeout enabled by defining TEMP_TIMEOUT_EN.
module temp_alarm_ctrl #(
    parameter int unsigned WARN_TH        = 200,
    parameter int unsigned SHDN_TH        = 250,
    parameter int unsigned HYST           = 10,
    parameter int unsigned DEBOUNCE       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       clr,
    output logic       alarm,
    output logic       sh,
    output logic [1:0] state,
    output logic [7:0] last_temp,
    output logic       sensor_fault
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE);
    localparam logic [7:0] WARN_B = 8'(WARN_TH);
    localparam logic [7:0] SHDN_B = 8'(SHDN_TH);
    localparam logic [7:0] COOL_B = 8'(WARN_TH - HYST);

    typedef enum logic [1:0] {
        S_NORMAL = 2'b00,
        S_WARN   = 2'b01,
        S_SHDN   = 2'b10,
        S_ILL    = 2'b11
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_hot_cnt;
    logic [CW-1:0]  r_warm_cnt;
    logic [CW-1:0]  r_cool_cnt;
    logic [CW-1:0]  w_hot_inc;
    logic [CW-1:0]  w_warm_inc;
    logic [CW-1:0]  w_cool_inc;
    logic [7:0]     r_last;
    logic           r_alarm;
    logic           r_sh;
    logic           w_alarm_nxt;
    logic           w_sh_nxt;
    logic           w_hot;
    logic           w_warm;
    logic           w_cool;
    logic           w_hot_reach;
    logic           w_warm_reach;
    logic           w_cool_reach;
    logic [7:0]     w_ref;
    logic           w_ref_cool;
    logic           w_trans;
    logic           w_to_hit;

    function automatic logic [CW-1:0] f_cnt(input logic hit,
                                            input logic [CW-1:0] c);
        if (!hit)
            return '0;
        else if (c == DB)
            return c;
        else
            return c + CW'(1);
    endfunction

    assign w_hot  = (rx_data >= SHDN_B);
    assign w_warm = (rx_data >= WARN_B);
    assign w_cool = (rx_data <  COOL_B);

    assign w_hot_inc  = f_cnt(w_hot,  r_hot_cnt);
    assign w_warm_inc = f_cnt(w_warm, r_warm_cnt);
    assign w_cool_inc = f_cnt(w_cool, r_cool_cnt);

    assign w_hot_reach  = rx_valid && w_hot  && (w_hot_inc  == DB);
    assign w_warm_reach = rx_valid && w_warm && (w_warm_inc == DB);
    assign w_cool_reach = rx_valid && w_cool && (w_cool_inc == DB);

    // A sample arriving with the clear takes precedence over the stored one
    assign w_ref      = rx_valid ? rx_data : r_last;
    assign w_ref_cool = (w_ref < COOL_B);

`ifdef TEMP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_fault;

    assign w_to_hit = !rx_valid && (r_to_cnt == TO_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_fault  <= 1'b0;
        end else if (rx_valid) begin
            r_to_cnt <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (r_to_cnt != TO_MAX)
                r_to_cnt <= r_to_cnt + TW'(1);
            if (w_to_hit)
                r_fault <= 1'b1;
        end
    end

    assign sensor_fault = r_fault;
`else
    assign w_to_hit     = 1'b0;
    assign sensor_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_NORMAL;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_NORMAL: begin
                if (w_hot_reach)
                    w_state_nxt = S_SHDN;
                else if (w_warm_reach)
                    w_state_nxt = S_WARN;
                else if (w_to_hit)
                    w_state_nxt = S_WARN;
            end
            S_WARN: begin
                if (w_hot_reach)
                    w_state_nxt = S_SHDN;
                else if (w_cool_reach)
                    w_state_nxt = S_NORMAL;
            end
            S_SHDN: begin
                if (clr && w_ref_cool)
                    w_state_nxt = S_NORMAL;
            end
            default: w_state_nxt = S_NORMAL;
        endcase
    end

    always_comb begin
        w_alarm_nxt = 1'b0;
        w_sh_nxt    = 1'b0;
        case (w_state_nxt)
            S_WARN:  w_alarm_nxt = 1'b1;
            S_SHDN:  w_sh_nxt    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= 1'b0;
            r_sh    <= 1'b0;
        end else begin
            r_alarm <= w_alarm_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    assign w_trans = (w_state_nxt != r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hot_cnt  <= '0;
            r_warm_cnt <= '0;
            r_cool_cnt <= '0;
        end else if (w_trans) begin
            r_hot_cnt  <= '0;
            r_warm_cnt <= '0;
            r_cool_cnt <= '0;
        end else if (rx_valid) begin
            r_hot_cnt  <= w_hot_inc;
            r_warm_cnt <= w_warm_inc;
            r_cool_cnt <= w_cool_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 8'd0;
        else if (rx_valid)
            r_last <= rx_data;
    end

    assign alarm     = r_alarm;
    assign sh        = r_sh;
    assign state     = r_state;
    assign last_temp = r_last;

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Scoreboard bench for temp_alarm_ctrl (timeout scenario only when
// TEMP_TIMEOUT_EN is defined).
module tb_temp_alarm_ctrl;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] W = 2'b01;
    localparam logic [1:0] S = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       clr = 1'b0;
    logic       alarm;
    logic       sh;
    logic [1:0] state;
    logic [7:0] last_temp;
    logic       sensor_fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] lt;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic [1:0] st;
        logic [7:0] lt;
    } stim_t;

    exp_t q[$];
    exp_t e;

    temp_alarm_ctrl dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .clr(clr), .alarm(alarm), .sh(sh), .state(state),
        .last_temp(last_temp), .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus and queue the state expected after that edge
    task automatic step(input stim_t s);
        @(negedge clk);
        rx_valid = s.v;
        rx_data  = s.d;
        clr      = s.c;
        q.push_back('{st: s.st, lt: s.lt});
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'd99;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({alarm, sh, state, last_temp, sensor_fault} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset: got al=%b sh=%b st=%b lt=%0d sf=%b, want all 0",
                     alarm, sh, state, last_temp, sensor_fault);
        end
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic test_normal;
        stim_t t[5] = '{
            '{1'b1, 8'd100, 1'b0, N, 8'd100},
            '{1'b1, 8'd100, 1'b0, N, 8'd100},
            '{1'b1, 8'd100, 1'b0, N, 8'd100},
            '{1'b1, 8'd100, 1'b0, N, 8'd100},
            '{1'b1, 8'd100, 1'b0, N, 8'd100}};
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL normal[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask

    task automatic test_warn;
        stim_t t[5] = '{
            '{1'b1, 8'd205, 1'b0, N, 8'd205},
            '{1'b1, 8'd150, 1'b0, N, 8'd150},
            '{1'b1, 8'd205, 1'b0, N, 8'd205},
            '{1'b1, 8'd205, 1'b0, N, 8'd205},
            '{1'b1, 8'd205, 1'b0, W, 8'd205}};
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL warn[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask

    task automatic test_hyst;
        stim_t t[7] = '{
            '{1'b1, 8'd195, 1'b0, W, 8'd195},
            '{1'b1, 8'd195, 1'b0, W, 8'd195},
            '{1'b1, 8'd195, 1'b0, W, 8'd195},
            '{1'b0, 8'd0,   1'b1, W, 8'd195},
            '{1'b1, 8'd189, 1'b0, W, 8'd189},
            '{1'b1, 8'd189, 1'b0, W, 8'd189},
            '{1'b1, 8'd189, 1'b0, N, 8'd189}};
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL hyst[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask

    task automatic test_boundary;
        stim_t t[15] = '{
            '{1'b1, 8'd199, 1'b0, N, 8'd199},
            '{1'b1, 8'd199, 1'b0, N, 8'd199},
            '{1'b1, 8'd199, 1'b0, N, 8'd199},
            '{1'b1, 8'd200, 1'b0, N, 8'd200},
            '{1'b1, 8'd200, 1'b0, N, 8'd200},
            '{1'b1, 8'd200, 1'b0, W, 8'd200},
            '{1'b1, 8'd190, 1'b0, W, 8'd190},
            '{1'b1, 8'd190, 1'b0, W, 8'd190},
            '{1'b1, 8'd190, 1'b0, W, 8'd190},
            '{1'b1, 8'd249, 1'b0, W, 8'd249},
            '{1'b1, 8'd249, 1'b0, W, 8'd249},
            '{1'b1, 8'd249, 1'b0, W, 8'd249},
            '{1'b1, 8'd250, 1'b0, W, 8'd250},
            '{1'b1, 8'd250, 1'b0, W, 8'd250},
            '{1'b1, 8'd250, 1'b0, S, 8'd250}};
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL boundary[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask

    task automatic test_shutdown;
        stim_t t[13] = '{
            '{1'b1, 8'd200, 1'b0, S, 8'd200},
            '{1'b0, 8'd0,   1'b1, S, 8'd200},
            '{1'b1, 8'd180, 1'b1, N, 8'd180},
            '{1'b1, 8'd251, 1'b0, N, 8'd251},
            '{1'b1, 8'd251, 1'b0, N, 8'd251},
            '{1'b1, 8'd251, 1'b0, S, 8'd251},
            '{1'b1, 8'd190, 1'b1, S, 8'd190},
            '{1'b1, 8'd150, 1'b0, S, 8'd150},
            '{1'b1, 8'd150, 1'b0, S, 8'd150},
            '{1'b1, 8'd150, 1'b0, S, 8'd150},
            '{1'b1, 8'd200, 1'b1, S, 8'd200},
            '{1'b1, 8'd150, 1'b0, S, 8'd150},
            '{1'b0, 8'd0,   1'b1, N, 8'd150}};
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL shutdown[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask

    task automatic test_back_to_back;
        stim_t t[8] = '{
            '{1'b1, 8'd205, 1'b0, N, 8'd205},
            '{1'b0, 8'd0,   1'b0, N, 8'd205},
            '{1'b1, 8'd205, 1'b0, N, 8'd205},
            '{1'b0, 8'd0,   1'b0, N, 8'd205},
            '{1'b1, 8'd205, 1'b0, W, 8'd205},
            '{1'b1, 8'd251, 1'b0, W, 8'd251},
            '{1'b1, 8'd251, 1'b0, W, 8'd251},
            '{1'b1, 8'd251, 1'b0, S, 8'd251}};
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask

    task automatic test_rst_in_shdn;
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'd77;
        clr = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({alarm, sh, state, last_temp, sensor_fault} !== 13'd0) begin
            n_fail++;
            $display("FAIL rst_shdn: got al=%b sh=%b st=%b lt=%0d sf=%b, want all 0",
                     alarm, sh, state, last_temp, sensor_fault);
        end
        rst = 1'b0;
        rx_valid = 1'b0;
    endtask

`ifdef TEMP_TIMEOUT_EN
    task automatic test_timeout;
        stim_t t[3] = '{
            '{1'b1, 8'd100, 1'b0, W, 8'd100},
            '{1'b1, 8'd100, 1'b0, W, 8'd100},
            '{1'b1, 8'd100, 1'b0, N, 8'd100}};
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (999) @(posedge clk);
        #1;
        n_checks++;
        if (sensor_fault !== 1'b0 || state !== N) begin
            n_fail++;
            $display("FAIL timeout_early: got sf=%b st=%b, want sf=0 st=00",
                     sensor_fault, state);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sensor_fault !== 1'b1 || state !== W || alarm !== 1'b1 || sh !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_hit: got sf=%b st=%b al=%b sh=%b, want sf=1 st=01 al=1 sh=0",
                     sensor_fault, state, alarm, sh);
        end
        foreach (t[i]) begin
            step(t[i]);
            e = q.pop_front();
            n_checks++;
            if ({state, alarm, sh, last_temp, sensor_fault} !==
                {e.st, e.st == W, e.st == S, e.lt, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_recover[%0d]: got st=%b al=%b sh=%b lt=%0d sf=%b, want st=%b lt=%0d sf=0",
                         i, state, alarm, sh, last_temp, sensor_fault, e.st, e.lt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_warn();
        test_hyst();
        test_boundary();
        test_shutdown();
        test_back_to_back();
        test_rst_in_shdn();
`ifdef TEMP_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
